mac_tx_dist: RTL and testbench

- Egress counterpart of the MAC RX arbiter: takes one 64B-cell stream on clk_dp, each packet tagged with a destination port, and distributes cells to 32 per-port SerDes TX cell interfaces.
- Sits between the egress cell source (TM read-out) and the top-level tx_* pins.
- Each port has a small cell FIFO so a backpressured port does not stall cells already queued for other ports.
- Enforces packet integrity: all cells of a packet go to the port latched at SOF.

---
 rtl/rv_p4_pkg.sv | 21 ++
 rtl/tx_cell_fifo.sv | 54 +++++
 rtl/mac_tx_dist.sv | 140 ++++++++++++++
 tb/tb_mac_tx_dist.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_p4_pkg.sv
// Shared types for the egress cell distributor: per-port FIFO cell record and port id.
package rv_p4_pkg;

    localparam int unsigned TX_FIFO_DEPTH = 4;

    typedef logic [4:0] port_id_t;

    typedef struct packed {
        logic         sof;
        logic         eof;
        logic [6:0]   eop_len;
        logic [511:0] data;
    } tx_cell_t;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDrop
    } tx_state_e;

endpackage

// File: rtl/tx_cell_fifo.sv
// Single-clock cell FIFO; head is forced to zero while empty so idle tx_* pins read 0.
module tx_cell_fifo
    import rv_p4_pkg::*;
#(
    parameter int unsigned DEPTH = TX_FIFO_DEPTH
) (
    input  logic     clk_dp,
    input  logic     rst_dp,
    input  logic     i_push,
    input  tx_cell_t i_cell,
    input  logic     i_pop,
    output tx_cell_t o_cell,
    output logic     o_full,
    output logic     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    tx_cell_t r_mem [DEPTH];
    ptr_t     r_wptr;
    ptr_t     r_rptr;
    cnt_t     r_count;
    logic     w_push;
    logic     w_pop;

    assign o_full  = (r_count == cnt_t'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_cell  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk_dp or posedge rst_dp) begin
        if (rst_dp) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ptr_t'(1);
            if (w_pop)  r_rptr <= r_rptr + ptr_t'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clk_dp) begin
        if (w_push) r_mem[r_wptr] <= i_cell;
    end

endmodule

// File: rtl/mac_tx_dist.sv
// Egress distributor: routes a tagged 64B-cell stream to per-port TX FIFOs, keeping
// every cell of a packet on the port latched at SOF.
module mac_tx_dist
    import rv_p4_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 32,
    parameter int unsigned CELL_W     = 512,
    parameter int unsigned LEN_W      = 7,
    parameter int unsigned FIFO_DEPTH = TX_FIFO_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk_dp,
    input  logic                       rst_dp,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic                       in_eof,
    input  logic [LEN_W-1:0]           in_eop_len,
    input  logic [CELL_W-1:0]          in_data,
    input  logic [4:0]                 in_port,
    output logic [NUM_PORTS-1:0]       tx_valid,
    output logic [NUM_PORTS-1:0]       tx_sof,
    output logic [NUM_PORTS-1:0]       tx_eof,
    output logic [NUM_PORTS*LEN_W-1:0] tx_eop_len,
    output logic [NUM_PORTS*CELL_W-1:0] tx_data,
    input  logic [NUM_PORTS-1:0]       tx_ready,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           err_cnt
);
    tx_state_e            r_state;
    tx_state_e            w_state_next;
    port_id_t             r_cur_port;
    port_id_t             w_cur_port_next;
    port_id_t             w_target;
    logic                 w_port_ok;
    logic                 w_discard;
    logic                 w_accept;
    logic                 w_push_en;
    logic                 w_drop_ev;
    logic                 w_err_ev;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [31:0]          w_full_ext;
    tx_cell_t             w_in_cell;
    tx_cell_t             w_head [NUM_PORTS];
    logic [CNT_W-1:0]     r_drop_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    assign w_in_cell = '{sof: in_sof, eof: in_eof, eop_len: in_eop_len, data: in_data};
    assign w_port_ok = (32'(in_port) < NUM_PORTS);
    assign w_accept  = in_valid && in_ready;
    assign drop_cnt  = r_drop_cnt;
    assign err_cnt   = r_err_cnt;

    // Padded full vector keeps the lookup in range for out-of-range port ids.
    always_comb begin
        w_full_ext = '0;
        w_full_ext[NUM_PORTS-1:0] = w_full;
        w_target = (r_state == StIdle || in_sof) ? in_port : r_cur_port;
        if (in_sof) begin
            w_discard = !w_port_ok;
        end else begin
            w_discard = (r_state != StFwd);
        end
        in_ready = w_discard || !w_full_ext[w_target];
    end

    always_comb begin
        w_state_next    = r_state;
        w_cur_port_next = r_cur_port;
        w_push_en       = 1'b0;
        w_drop_ev       = 1'b0;
        w_err_ev        = 1'b0;
        if (w_accept) begin
            if (in_sof) begin
                // A SOF outside IDLE truncates the open packet and restarts here.
                w_err_ev = (r_state != StIdle);
                if (w_port_ok) begin
                    w_cur_port_next = in_port;
                    w_push_en       = 1'b1;
                    w_state_next    = in_eof ? StIdle : StFwd;
                end else begin
                    w_drop_ev    = 1'b1;
                    w_state_next = in_eof ? StIdle : StDrop;
                end
            end else begin
                case (r_state)
                    StIdle: w_err_ev = 1'b1;
                    StFwd: begin
                        w_push_en = 1'b1;
                        if (in_eof) w_state_next = StIdle;
                    end
                    StDrop: begin
                        if (in_eof) w_state_next = StIdle;
                    end
                    default: w_state_next = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_dp or posedge rst_dp) begin
        if (rst_dp) begin
            r_state    <= StIdle;
            r_cur_port <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cur_port <= w_cur_port_next;
            if (w_drop_ev && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            if (w_err_ev && r_err_cnt != '1)   r_err_cnt  <= r_err_cnt + CNT_W'(1);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_push[p] = w_push_en && (w_target == 5'(p));

        tx_cell_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_dp  (clk_dp),
            .rst_dp  (rst_dp),
            .i_push  (w_push[p]),
            .i_cell  (w_in_cell),
            .i_pop   (tx_ready[p]),
            .o_cell  (w_head[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p])
        );

        assign tx_valid[p]                   = !w_empty[p];
        assign tx_sof[p]                     = w_head[p].sof;
        assign tx_eof[p]                     = w_head[p].eof;
        assign tx_eop_len[p*LEN_W +: LEN_W]  = w_head[p].eop_len;
        assign tx_data[p*CELL_W +: CELL_W]   = w_head[p].data;
    end

endmodule

// File: tb/tb_mac_tx_dist.sv
// Bench for mac_tx_dist: table-driven input cells, per-port scoreboard checked every cycle.
module tb_mac_tx_dist;
    localparam int NP   = 16;
    localparam int CW   = 512;
    localparam int LW   = 7;
    localparam int CNTW = 16;

    logic             clk_dp;
    logic             rst_dp;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_eof;
    logic [LW-1:0]    in_eop_len;
    logic [CW-1:0]    in_data;
    logic [4:0]       in_port;
    logic [NP-1:0]    tx_valid;
    logic [NP-1:0]    tx_sof;
    logic [NP-1:0]    tx_eof;
    logic [NP*LW-1:0] tx_eop_len;
    logic [NP*CW-1:0] tx_data;
    logic [NP-1:0]    tx_ready;
    logic [CNTW-1:0]  drop_cnt;
    logic [CNTW-1:0]  err_cnt;

    mac_tx_dist #(
        .NUM_PORTS (NP),
        .CELL_W    (CW),
        .LEN_W     (LW),
        .FIFO_DEPTH(4),
        .CNT_W     (CNTW)
    ) dut (
        .clk_dp    (clk_dp),
        .rst_dp    (rst_dp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_eop_len(in_eop_len),
        .in_data   (in_data),
        .in_port   (in_port),
        .tx_valid  (tx_valid),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof),
        .tx_eop_len(tx_eop_len),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .drop_cnt  (drop_cnt),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic        valid;
        logic        sof;
        logic        eof;
        logic [6:0]  len;
        logic [4:0]  port;
        logic [31:0] tag;
        logic        exp_ready;
        int          dest;
    } vec_t;

    typedef struct {
        int          port;
        logic        sof;
        logic        eof;
        logic [6:0]  len;
        logic [31:0] tag;
    } exp_t;

    exp_t          sb[$];
    logic [NP-1:0] pop_pend;
    int            checks;
    int            failures;
    bit            mon_en;
    vec_t          vt [0:15];

    initial clk_dp = 1'b0;
    always #5 clk_dp = ~clk_dp;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sof, input logic eof, input logic [6:0] len,
                                input logic [4:0] port, input logic [31:0] tag,
                                input logic rdy, input int dest);
        vec_t v;
        v.valid = 1'b1; v.sof = sof; v.eof = eof; v.len = len; v.port = port;
        v.tag = tag; v.exp_ready = rdy; v.dest = dest;
        return v;
    endfunction

    // Entered just after a rising edge; returns on the edge that samples the cell.
    task automatic apply(input vec_t v);
        exp_t e;
        #1;
        in_valid   = v.valid;
        in_sof     = v.sof;
        in_eof     = v.eof;
        in_eop_len = v.len;
        in_port    = v.port;
        in_data    = {16{v.tag}};
        @(negedge clk_dp);
        check(in_ready == v.exp_ready, $sformatf("in_ready tag=%0d", v.tag), in_ready,
              v.exp_ready);
        @(posedge clk_dp);
        if (v.valid && v.exp_ready && v.dest >= 0) begin
            e.port = v.dest; e.sof = v.sof; e.eof = v.eof; e.len = v.len; e.tag = v.tag;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        @(posedge clk_dp);
    endtask

    // Output monitor: each port must show exactly the oldest expected cell for that port.
    always @(negedge clk_dp) begin : mon
        int idx;
        bit ok;
        if (mon_en && !rst_dp) begin
            for (int p = 0; p < NP; p++) begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].port == p) idx = i;
                check(tx_valid[p] == (idx >= 0), $sformatf("tx_valid[%0d]", p), tx_valid[p],
                      64'(idx >= 0));
                if (tx_valid[p] && idx >= 0) begin
                    ok = (tx_sof[p] == sb[idx].sof) && (tx_eof[p] == sb[idx].eof) &&
                         (tx_eop_len[p*LW +: LW] == sb[idx].len) &&
                         (tx_data[p*CW +: CW] == {16{sb[idx].tag}});
                    check(ok, $sformatf("tx_cell[%0d]", p),
                          {tx_sof[p], tx_eof[p], tx_data[p*CW +: 32]},
                          {sb[idx].sof, sb[idx].eof, sb[idx].tag});
                    pop_pend[p] = tx_ready[p];
                end
            end
        end
    end

    always @(posedge clk_dp) begin : popper
        bit done;
        if (!rst_dp) begin
            for (int p = 0; p < NP; p++) begin
                if (pop_pend[p]) begin
                    pop_pend[p] = 1'b0;
                    done = 1'b0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!done && sb[i].port == p) begin
                            sb.delete(i);
                            done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks = 0; failures = 0; mon_en = 1'b0; pop_pend = '0;
        rst_dp = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_eop_len = '0; in_data = '0; in_port = '0; tx_ready = '1;

        //            sof   eof   len    port   tag rdy dest
        vt[0]  = mk(1'b1, 1'b1, 7'd60, 5'd5,  1,  1'b1, 5);
        vt[1]  = mk(1'b1, 1'b0, 7'd0,  5'd2,  2,  1'b1, 2);
        vt[2]  = mk(1'b0, 1'b0, 7'd0,  5'd9,  3,  1'b1, 2);
        vt[3]  = mk(1'b0, 1'b1, 7'd10, 5'd9,  4,  1'b1, 2);
        vt[4]  = mk(1'b1, 1'b0, 7'd0,  5'd20, 5,  1'b1, -1);
        vt[5]  = mk(1'b0, 1'b1, 7'd64, 5'd3,  6,  1'b1, -1);
        vt[6]  = mk(1'b0, 1'b0, 7'd0,  5'd1,  7,  1'b1, -1);
        vt[7]  = mk(1'b1, 1'b0, 7'd0,  5'd6,  8,  1'b1, 6);
        vt[8]  = mk(1'b1, 1'b0, 7'd0,  5'd7,  9,  1'b1, 7);
        vt[9]  = mk(1'b0, 1'b1, 7'd33, 5'd0,  10, 1'b1, 7);
        vt[10] = mk(1'b1, 1'b0, 7'd0,  5'd3,  11, 1'b1, 3);
        vt[11] = mk(1'b0, 1'b0, 7'd0,  5'd3,  12, 1'b1, 3);
        vt[12] = mk(1'b0, 1'b0, 7'd0,  5'd3,  13, 1'b1, 3);
        vt[13] = mk(1'b0, 1'b0, 7'd0,  5'd3,  14, 1'b1, 3);
        vt[14] = mk(1'b0, 1'b1, 7'd5,  5'd3,  15, 1'b0, 3);
        vt[15] = mk(1'b1, 1'b1, 7'd1,  5'd4,  16, 1'b1, 4);

        repeat (2) @(negedge clk_dp);
        #1;
        check(tx_valid == '0, "rst_tx_valid", 64'(tx_valid), 0);
        check(tx_data == '0 && tx_sof == '0 && tx_eof == '0 && tx_eop_len == '0,
              "rst_tx_fields", 64'(|tx_data), 0);
        check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        check(drop_cnt == 0 && err_cnt == 0, "rst_counters", {drop_cnt, err_cnt}, 0);
        @(negedge clk_dp);
        rst_dp = 1'b0;
        mon_en = 1'b1;
        @(posedge clk_dp);

        for (int i = 0; i < 10; i++) apply(vt[i]);
        idle();
        #1;
        check(drop_cnt == 1, "drop_cnt", drop_cnt, 1);
        check(err_cnt == 2, "err_cnt", err_cnt, 2);

        // Port 3 stalled: four cells fill its FIFO, the fifth waits.
        tx_ready[3] = 1'b0;
        for (int i = 10; i < 15; i++) apply(vt[i]);
        repeat (3) begin
            @(negedge clk_dp);
            check(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
            @(posedge clk_dp);
        end
        #1;
        tx_ready[3] = 1'b1;
        @(negedge clk_dp);
        check(in_ready == 1'b0, "no_full_bypass", in_ready, 0);
        @(posedge clk_dp);
        vt[14].exp_ready = 1'b1;
        apply(vt[14]);
        apply(vt[15]);
        repeat (6) idle();
        check(drop_cnt == 1 && err_cnt == 2, "counters_after_stall", {drop_cnt, err_cnt},
              {16'd1, 16'd2});

        // Reset with two cells parked on port 7 and the packet still open.
        #1;
        tx_ready[7] = 1'b0;
        apply(mk(1'b1, 1'b0, 7'd0, 5'd7, 20, 1'b1, 7));
        apply(mk(1'b0, 1'b0, 7'd0, 5'd7, 21, 1'b1, 7));
        #2;
        rst_dp   = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        sb.delete();
        pop_pend = '0;
        #1;
        check(tx_valid == '0, "midrst_tx_valid", 64'(tx_valid), 0);
        check(drop_cnt == 0 && err_cnt == 0, "midrst_counters", {drop_cnt, err_cnt}, 0);
        check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
        tx_ready[7] = 1'b1;
        repeat (2) @(posedge clk_dp);
        @(negedge clk_dp);
        rst_dp = 1'b0;
        @(posedge clk_dp);
        apply(mk(1'b1, 1'b1, 7'd42, 5'd7, 22, 1'b1, 7));
        repeat (3) idle();
        check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
